// File: rtl/input_controller.sv
// Button front end: two-flop sync, tick-sampled debounce, round-robin arbitration of
// direction presses, and a valid/ready direction output with a pause toggle.
module input_controller #(
  parameter int CLK_DIV      = 250000,
  parameter int STABLE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_pause,
  input  logic       move_ready,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic       paused
);

  localparam int NBTN      = 5;
  localparam int PAUSE_IDX = 4;
  localparam int TICK_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W     = $clog2(STABLE_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(STABLE_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    PAUSED = 2'd2
  } state_e;

  // Bit order matches the dir encoding: up=0, down=1, left=2, right=3, pause=4.
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync1_q, sync2_q;
  assign raw = {btn_pause, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Sample-tick divider.
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick;

  assign tick   = (tick_q == TICK_LAST);
  assign tick_d = tick ? '0 : tick_q + TICK_ONE;

  always_ff @(posedge clk) begin
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;
  end

  // Debounce: a level is accepted after STABLE_TICKS consecutive differing samples.
  logic [NBTN-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] count_q [NBTN];
  logic [CNT_W-1:0] count_d [NBTN];
  logic [NBTN-1:0]  press;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    stable_d = stable_q;
    count_d  = count_q;
    if (tick) begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          count_d[i] = '0;
        end else if (count_q[i] + CNT_ONE == CNT_LIMIT) begin
          stable_d[i] = sync2_q[i];
          count_d[i]  = '0;
        end else begin
          count_d[i] = count_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      // NOTE: this small counter array is control state, so it is reset like any register.
      for (int i = 0; i < NBTN; i++) count_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      count_q  <= count_d;
    end
  end

  // A 0->1 acceptance is a single-cycle press; releases produce nothing.
  assign press = stable_d & ~stable_q;

  logic [3:0] dir_ev;
  logic       pause_ev;
  assign dir_ev   = press[3:0];
  assign pause_ev = press[PAUSE_IDX];

  // Round-robin: search starts just after the previous winner; losers are dropped.
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] winner, idx;
  logic       grant;

  always_comb begin
    grant  = 1'b0;
    winner = last_grant_q;
    idx    = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant_q + 2'(k);
      if (!grant && dir_ev[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
  end

  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       load;

  // A grant is used only when running and not coinciding with a pause press.
  assign load         = grant && !pause_ev && (state_q != PAUSED);
  assign dir_d        = load ? winner : dir_q;
  assign last_grant_d = load ? winner : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dir_q        <= 2'b00;
      last_grant_q <= 2'b11;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pause_ev)   state_d = PAUSED;
        else if (grant) state_d = HOLD;
      end
      HOLD: begin
        if (pause_ev)                  state_d = PAUSED;
        else if (!grant && move_ready) state_d = IDLE;
      end
      PAUSED: begin
        if (pause_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dir_valid = (state_q == HOLD);
    paused    = (state_q == PAUSED);
    dir       = dir_q;
  end

endmodule
